difftest_fp_wb_arbiter: RTL and testbench

//  Merges FP-register writeback events from NUM_PORTS writeback ports into one

---
 rtl/difftest_fp_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_difftest_fp_wb_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/difftest_fp_wb_arbiter.sv
// Merges FP writeback events from NUM_PORTS ports through per-port FIFOs and a
// round-robin scheduler into one registered event per cycle for the difftest sink.
module difftest_fp_wb_arbiter_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 72
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr, r_rptr;

    // Extra pointer bit tells full from empty when the index bits match.
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty = (r_wptr == r_rptr);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (i_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
endmodule

module difftest_fp_wb_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        in_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0] in_address,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    output logic [NUM_PORTS-1:0]        in_ready,
    input  logic [7:0]                  io_coreid,
    output logic                        out_enable,
    output logic                        out_valid,
    output logic [ADDR_W-1:0]           out_address,
    output logic [DATA_W-1:0]           out_data,
    output logic [7:0]                  out_coreid,
    input  logic                        out_ready,
    output logic                        overflow_err,
    output logic [15:0]                 drop_cnt
);
    localparam int EW = ADDR_W + DATA_W;
    localparam int PW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]         w_full, w_empty, w_push, w_pop, w_drop;
    logic [NUM_PORTS-1:0][EW-1:0] w_head;
    logic [PW-1:0]                r_rr, w_gnt_idx, w_rr_nxt;
    logic                         w_gnt_vld, w_load;
    logic                         r_out_valid, r_ovf;
    logic [ADDR_W-1:0]            r_addr;
    logic [DATA_W-1:0]            r_data;
    logic [7:0]                   r_core;
    logic [15:0]                  r_drop;
    logic [3:0]                   w_ndrop;
    logic [16:0]                  w_drop_sum;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        difftest_fp_wb_arbiter_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
            .clock   (clock),
            .reset   (reset),
            .i_push  (w_push[g]),
            .i_wdata ({in_address[g*ADDR_W +: ADDR_W], in_data[g*DATA_W +: DATA_W]}),
            .i_pop   (w_pop[g]),
            .o_rdata (w_head[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );
    end

    // Readiness is occupancy-only: a full FIFO refuses even when it pops this cycle.
    assign in_ready = ~w_full;
    assign w_push   = in_valid & ~w_full;
    assign w_drop   = in_valid & w_full;
    assign w_load   = !r_out_valid || out_ready;

    // Scan from the pointer upward with wrap; iterating backwards lets the nearest candidate win.
    always_comb begin
        logic [PW:0] w_sum;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        for (int off = NUM_PORTS - 1; off >= 0; off--) begin
            w_sum = {1'b0, r_rr} + (PW+1)'(off);
            if (w_sum >= (PW+1)'(NUM_PORTS)) w_sum = w_sum - (PW+1)'(NUM_PORTS);
            if (!w_empty[w_sum[PW-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_sum[PW-1:0];
            end
        end
    end

    assign w_rr_nxt = (w_gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : w_gnt_idx + PW'(1);

    always_comb begin
        w_pop = '0;
        if (w_load && w_gnt_vld) w_pop[w_gnt_idx] = 1'b1;
    end

    always_comb begin
        w_ndrop = '0;
        for (int i = 0; i < NUM_PORTS; i++) w_ndrop = w_ndrop + {3'b000, w_drop[i]};
    end

    assign w_drop_sum = {1'b0, r_drop} + {13'd0, w_ndrop};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_core      <= '0;
            r_rr        <= '0;
            r_ovf       <= 1'b0;
            r_drop      <= '0;
        end else begin
            if (w_load) begin
                r_out_valid <= w_gnt_vld;
                if (w_gnt_vld) begin
                    r_addr <= w_head[w_gnt_idx][EW-1:DATA_W];
                    r_data <= w_head[w_gnt_idx][DATA_W-1:0];
                    r_core <= io_coreid;
                    r_rr   <= w_rr_nxt;
                end
            end
            if (|w_drop) r_ovf <= 1'b1;
            r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign out_valid    = r_out_valid;
    assign out_enable   = r_out_valid;
    assign out_address  = r_addr;
    assign out_data     = r_data;
    assign out_coreid   = r_core;
    assign overflow_err = r_ovf;
    assign drop_cnt     = r_drop;
endmodule

// File: tb/tb_difftest_fp_wb_arbiter.sv
// Scoreboard bench: a queue-level reference model predicts every presented event,
// and a negedge monitor compares DUT status and consumed events against it.
module tb_difftest_fp_wb_arbiter;
    localparam int NP = 4;
    localparam int D  = 4;
    localparam int AW = 8;
    localparam int DW = 64;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [7:0]    core;
    } ev_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [NP-1:0]    in_valid;
    logic [NP*AW-1:0] in_address;
    logic [NP*DW-1:0] in_data;
    logic [NP-1:0]    in_ready;
    logic [7:0]       io_coreid;
    logic             out_enable, out_valid;
    logic [AW-1:0]    out_address;
    logic [DW-1:0]    out_data;
    logic [7:0]       out_coreid;
    logic             out_ready;
    logic             overflow_err;
    logic [15:0]      drop_cnt;

    int  n_chk = 0;
    int  n_err = 0;
    bit  started = 0;

    ev_t mq [NP][$];
    ev_t exp_q [$];
    bit  m_ov, m_ovf;
    int  m_rr, m_drop;

    difftest_fp_wb_arbiter #(.NUM_PORTS(NP), .DEPTH(D), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_address   (in_address),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .io_coreid    (io_coreid),
        .out_enable   (out_enable),
        .out_valid    (out_valid),
        .out_address  (out_address),
        .out_data     (out_data),
        .out_coreid   (out_coreid),
        .out_ready    (out_ready),
        .overflow_err (overflow_err),
        .drop_cnt     (drop_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] m_rdy();
        logic [NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i] = (mq[i].size() < D);
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NP; i++) mq[i].delete();
        exp_q.delete();
        m_ov = 0; m_ovf = 0; m_rr = 0; m_drop = 0;
    endfunction

    // One clock edge of the reference: drops, then RR grant on pre-edge contents, then pushes.
    function automatic void model_edge();
        logic [NP-1:0] rdy;
        int  k;
        ev_t ev;
        rdy = m_rdy();
        k   = -1;
        for (int i = 0; i < NP; i++)
            if (in_valid[i] && !rdy[i]) begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop++;
            end
        if (!m_ov || out_ready) begin
            for (int off = 0; off < NP; off++)
                if (k < 0 && mq[(m_rr + off) % NP].size() > 0) k = (m_rr + off) % NP;
            if (k >= 0) begin
                ev      = mq[k].pop_front();
                ev.core = io_coreid;
                exp_q.push_back(ev);
                m_ov = 1;
                m_rr = (k + 1) % NP;
            end else begin
                m_ov = 0;
            end
        end
        for (int i = 0; i < NP; i++)
            if (in_valid[i] && rdy[i]) begin
                ev.addr = in_address[i*AW +: AW];
                ev.data = in_data[i*DW +: DW];
                ev.core = 8'h00;
                mq[i].push_back(ev);
            end
    endfunction

    always @(negedge clock) begin
        ev_t e;
        if (started) begin
            chk("out_valid",    64'(out_valid),    64'(m_ov));
            chk("out_enable",   64'(out_enable),   64'(m_ov));
            chk("in_ready",     64'(in_ready),     64'(m_rdy()));
            chk("drop_cnt",     64'(drop_cnt),     64'(m_drop));
            chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
            if (reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_event: got addr %0h, expected no event", out_address);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_addr", 64'(out_address), 64'(e.addr));
                    chk("ev_data", out_data,         e.data);
                    chk("ev_core", 64'(out_coreid),  64'(e.core));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        if (reset) model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        started = 1;
    endtask

    task automatic set_port(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_address[i*AW +: AW] = a;
        in_data[i*DW +: DW]    = d;
    endtask

    initial begin
        in_valid   = '0;
        in_address = '0;
        in_data    = '0;
        io_coreid  = '0;
        out_ready  = 1'b0;

        // Reset state
        do_reset();
        chk("rst_out_valid", 64'(out_valid),   64'd0);
        chk("rst_addr",      64'(out_address), 64'd0);
        chk("rst_data",      out_data,         64'd0);
        chk("rst_core",      64'(out_coreid),  64'd0);
        chk("rst_in_ready",  64'(in_ready),    64'hF);

        // Single event, two-edge latency
        io_coreid = 8'h00;
        out_ready = 1'b1;
        in_valid  = 4'b0001;
        set_port(0, 8'h05, 64'h3FF0_0000_0000_0000);
        tick();
        in_valid = '0;
        chk("t1_not_yet", 64'(out_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(out_valid),   64'd1);
        chk("t1_addr",  64'(out_address), 64'h05);
        chk("t1_data",  out_data,         64'h3FF0_0000_0000_0000);
        tick();
        chk("t1_pulse", 64'(out_valid), 64'd0);
        chk("t1_drops", 64'(drop_cnt),  64'd0);

        // All ports at once drain in index order, pointer wraps to 0
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'hF;
        for (int i = 0; i < NP; i++) set_port(i, AW'(i), {$urandom, $urandom});
        tick();
        in_valid = '0;
        for (int j = 0; j < NP; j++) begin
            tick();
            chk("t2_valid", 64'(out_valid),   64'd1);
            chk("t2_order", 64'(out_address), 64'(j));
        end
        tick();
        chk("t2_idle", 64'(out_valid), 64'd0);
        in_valid = 4'b1001;
        set_port(0, 8'hA0, 64'h1);
        set_port(3, 8'hA3, 64'h3);
        tick();
        in_valid = '0;
        tick();
        chk("t2_ptr_at0", 64'(out_address), 64'hA0);
        repeat (3) tick();

        // Back-pressure on port 2: four in FIFO plus one in output reg, sixth drops
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 4'b0100;
            set_port(2, AW'(8'h20 + k), {$urandom, $urandom});
            tick();
            if (k == 4) chk("t3_full", 64'(in_ready[2]), 64'd0);
        end
        in_valid = '0;
        chk("t3_ovf",  64'(overflow_err), 64'd1);
        chk("t3_drop", 64'(drop_cnt),     64'd1);
        out_ready = 1'b1;
        repeat (8) tick();
        chk("t3_drained", 64'(exp_q.size()), 64'd0);

        // Ports 1 and 3 streaming while ready: grants alternate
        do_reset();
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            in_valid = 4'b1010 & m_rdy();
            set_port(1, 8'h01, {$urandom, $urandom});
            set_port(3, 8'h03, {$urandom, $urandom});
            tick();
            if (j >= 1) chk("t4_alt", 64'(out_address), (j % 2 == 1) ? 64'd1 : 64'd3);
        end
        in_valid = '0;
        chk("t4_nodrop", 64'(drop_cnt), 64'd0);
        repeat (12) tick();

        // Reset mid-burst discards everything
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 4'b0001;
            set_port(0, AW'(8'h50 + k), {$urandom, $urandom});
            tick();
        end
        in_valid = '0;
        chk("t5_busy", 64'(out_valid), 64'd1);
        reset = 1'b0;
        model_reset();
        #1;
        chk("t5_async_clr", 64'(out_valid), 64'd0);
        do_reset();
        chk("t5_in_ready", 64'(in_ready), 64'hF);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_no_stale", 64'(out_valid), 64'd0);
        end

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid  = NP'($urandom);
            for (int i = 0; i < NP; i++) set_port(i, AW'($urandom), {$urandom, $urandom});
            io_coreid = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (30) tick();
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        // Drop counter saturation
        do_reset();
        out_ready = 1'b0;
        while (m_drop < 65535) begin
            int rem;
            rem      = 65535 - m_drop;
            in_valid = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
            tick();
        end
        in_valid = '0;
        tick();
        chk("t6_at_max", 64'(drop_cnt), 64'hFFFF);
        in_valid = 4'b0011;
        tick();
        in_valid = '0;
        tick();
        chk("t6_saturated", 64'(drop_cnt), 64'hFFFF);
        chk("t6_ovf",       64'(overflow_err), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
